// File: rtl/redbus_controller_if.sv
// CPU, configuration and redbus control signals of the redbus controller.
// The redbus data line is bidirectional and stays a plain module port.
interface redbus_controller_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_read;
  logic        cpu_write;
  logic        hit_c;
  logic        ready;
  logic        cfg_write;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic [15:0] address;
  logic        read_redbus;
  logic        write_redbus;
  logic        enable;
  logic [7:0]  device_id;

  modport slave (
    input  cpu_address, cpu_data_in, cpu_read, cpu_write,
    input  cfg_write, cfg_sel, cfg_data,
    output cpu_data_out, hit_c, ready,
    output address, read_redbus, write_redbus, enable, device_id
  );

  modport master (
    output cpu_address, cpu_data_in, cpu_read, cpu_write,
    output cfg_write, cfg_sel, cfg_data,
    input  cpu_data_out, hit_c, ready,
    input  address, read_redbus, write_redbus, enable, device_id
  );
endinterface

// File: rtl/redbus_controller.sv
// Maps a 256-byte CPU window onto the redbus: SETUP, STROBE x N, HOLD, DONE.
// All bus-facing outputs are registered alongside the state.
module redbus_controller #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned WINDOW_SIZE   = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  redbus_controller_if.slave  bus,
  inout  wire  [7:0]          data
);
  localparam int unsigned OFS_W  = $clog2(WINDOW_SIZE);
  localparam int unsigned BASE_W = 16 - OFS_W;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OFS_W-1:0]  offset_q, offset_d;
  logic              is_read_q, is_read_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [7:0]        dev_id_q, dev_id_d;
  logic              bus_en_q, bus_en_d;
  logic [7:0]        dout_q, dout_d;
  logic              enable_q, enable_d;
  logic [15:0]       address_q, address_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ready_q, ready_d;
  logic              data_oe_q, data_oe_d;
  logic              active_d;
  logic              req;

  assign bus.hit_c = (bus.cpu_address[15:OFS_W] == base_q);
  assign req       = bus.cpu_read | bus.cpu_write;

  // Next state, configuration updates and next registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    offset_d  = offset_q;
    is_read_d = is_read_q;
    wdata_d   = wdata_q;
    base_d    = base_q;
    dev_id_d  = dev_id_q;
    bus_en_d  = bus_en_q;
    dout_d    = dout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_write) begin
          case (bus.cfg_sel)
            2'd0:    base_d   = bus.cfg_data[15:OFS_W];
            2'd1:    dev_id_d = bus.cfg_data[7:0];
            2'd2:    bus_en_d = bus.cfg_data[0];
            default: ;
          endcase
        end
        if (bus.hit_c && req) begin
          if (bus_en_q) begin
            state_d   = S_SETUP;
            offset_d  = bus.cpu_address[OFS_W-1:0];
            is_read_d = bus.cpu_read;
            wdata_d   = bus.cpu_data_in;
          end else begin
            // Bus disabled: complete at once with zero read data
            state_d = S_DONE;
            dout_d  = 8'h00;
          end
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end
      S_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          if (is_read_q) dout_d = data;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    active_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    enable_d  = active_d;
    address_d = active_d ? 16'(offset_d) : 16'h0000;
    data_oe_d = active_d && !is_read_d;
    rd_d      = (state_d == S_STROBE) && is_read_d;
    wr_d      = (state_d == S_STROBE) && !is_read_d;
    ready_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      offset_q  <= '0;
      is_read_q <= 1'b0;
      wdata_q   <= 8'h00;
      base_q    <= '0;
      dev_id_q  <= 8'h00;
      bus_en_q  <= 1'b0;
      dout_q    <= 8'h00;
      enable_q  <= 1'b0;
      address_q <= 16'h0000;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      is_read_q <= is_read_d;
      wdata_q   <= wdata_d;
      base_q    <= base_d;
      dev_id_q  <= dev_id_d;
      bus_en_q  <= bus_en_d;
      dout_q    <= dout_d;
      enable_q  <= enable_d;
      address_q <= address_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign data             = data_oe_q ? wdata_q : 'z;
  assign bus.cpu_data_out = dout_q;
  assign bus.ready        = ready_q;
  assign bus.address      = address_q;
  assign bus.read_redbus  = rd_q;
  assign bus.write_redbus = wr_q;
  assign bus.enable       = enable_q;
  assign bus.device_id    = dev_id_q;
endmodule

// File: tb/tb_redbus_controller.sv
// Directed bench for redbus_controller: a transaction-timeline model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_redbus_controller;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire [7:0] data;

  redbus_controller_if bus ();

  redbus_controller #(.STROBE_CYCLES(S), .WINDOW_SIZE(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .data  (data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] periph(input logic [7:0] off);
    return (off == 8'h00) ? 8'h3C : (off ^ 8'h5A);
  endfunction

  // Model peripheral answers reads while ReadRedbus is high
  assign data = bus.read_redbus ? periph(bus.address[7:0]) : 8'hzz;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: one transaction described by its start cycle; outputs follow from elapsed cycles
  int          cyc = 0;
  bit          m_valid = 0;
  int          m_start = 0;
  int          m_end = 0;
  bit          m_read = 0;
  bit          m_bypass = 0;
  logic [7:0]  m_off = 8'h00;
  logic [7:0]  m_wdata = 8'h00;
  logic [7:0]  m_base = 8'h00;
  logic [7:0]  m_id = 8'h00;
  bit          m_en = 0;
  logic [7:0]  m_dout = 8'h00;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_valid = 0; m_base = 8'h00; m_id = 8'h00; m_en = 0; m_dout = 8'h00; cyc = 0;
    end else begin
      int  kp;
      bit  busy;
      cyc++;
      kp   = cyc - 1 - m_start;
      busy = m_valid && (kp >= 1) && (kp <= m_end);
      if (m_valid && !m_bypass && m_read && kp == 1 + S) m_dout = periph(m_off);
      if (!busy) begin
        if ((bus.cpu_address[15:8] == m_base) && (bus.cpu_read || bus.cpu_write)) begin
          m_valid  = 1;
          m_start  = cyc - 1;
          m_read   = bus.cpu_read;
          m_off    = bus.cpu_address[7:0];
          m_wdata  = bus.cpu_data_in;
          m_bypass = !m_en;
          m_end    = m_en ? 3 + S : 1;
          if (!m_en) m_dout = 8'h00;
        end
        if (bus.cfg_write) begin
          case (bus.cfg_sel)
            2'd0:    m_base = bus.cfg_data[15:8];
            2'd1:    m_id   = bus.cfg_data[7:0];
            2'd2:    m_en   = bus.cfg_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    int k;
    bit act, stb;
    @(negedge clk);
    k   = cyc - m_start;
    act = m_valid && !m_bypass && (k >= 1) && (k <= 2 + S);
    stb = m_valid && !m_bypass && (k >= 2) && (k <= 1 + S);
    chk("enable", 16'(bus.enable), 16'(act));
    chk("address", bus.address, act ? {8'h00, m_off} : 16'h0000);
    chk("read_redbus", 16'(bus.read_redbus), 16'(stb && m_read));
    chk("write_redbus", 16'(bus.write_redbus), 16'(stb && !m_read));
    chk("ready", 16'(bus.ready), 16'(m_valid && (k == m_end)));
    chk("cpu_data_out", 16'(bus.cpu_data_out), 16'(m_dout));
    chk("device_id", 16'(bus.device_id), 16'(m_id));
    chk("hit", 16'(bus.hit_c), 16'(bus.cpu_address[15:8] == m_base));
    if (act && !m_read) chk("data", 16'(data), 16'(m_wdata));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [15:0] d);
    bus.cfg_write = 1'b1; bus.cfg_sel = sel; bus.cfg_data = d;
    tick();
    bus.cfg_write = 1'b0;
  endtask

  task automatic access(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] wd,
                        input int inj, output int lat, output int nrd, output int nwr,
                        output int nen, output logic [15:0] saddr, output logic [7:0] sdata);
    lat = -1; nrd = 0; nwr = 0; nen = 0; saddr = 16'hxxxx; sdata = 8'hxx;
    bus.cpu_address = a; bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_data_in = wd;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.read_redbus) nrd++;
      if (bus.write_redbus) begin nwr++; saddr = bus.address; sdata = data; end
      if (bus.enable) nen++;
      if (i == inj) begin bus.cfg_write = 1'b1; bus.cfg_sel = 2'd1; bus.cfg_data = 16'h0007; end
      else bus.cfg_write = 1'b0;
      if (bus.ready) begin lat = i; break; end
    end
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cfg_write = 1'b0;
  endtask

  initial begin
    int lat, nrd, nwr, nen, cnt;
    logic [15:0] sa;
    logic [7:0]  sd;
    bus.cpu_address = 16'h0000; bus.cpu_data_in = 8'h00; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    bus.cfg_write = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = 16'h0000;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst ready", 16'(bus.ready), 16'd0);
    chk("rst dout", 16'(bus.cpu_data_out), 16'h0000);
    rst_n = 1'b1;
    tick();

    cfg(2'd0, 16'hFF00);
    cfg(2'd2, 16'h0001);

    // Write FF02 <- A5
    access(16'hFF02, 1'b0, 1'b1, 8'hA5, 0, lat, nrd, nwr, nen, sa, sd);
    chk("wr latency", 16'(lat), 16'd5);
    chk("wr strobes", 16'(nwr), 16'd2);
    chk("wr no rd", 16'(nrd), 16'd0);
    chk("wr address", sa, 16'h0002);
    chk("wr data", 16'(sd), 16'h00A5);
    tick();

    // Read FF00 -> 3C from peripheral
    access(16'hFF00, 1'b1, 1'b0, 8'h00, 0, lat, nrd, nwr, nen, sa, sd);
    chk("rd latency", 16'(lat), 16'd5);
    chk("rd strobes", 16'(nrd), 16'd2);
    chk("rd dout", 16'(bus.cpu_data_out), 16'h003C);
    tick();

    // Window edges
    access(16'hFFFF, 1'b0, 1'b1, 8'h5A, 0, lat, nrd, nwr, nen, sa, sd);
    chk("wr FFFF address", sa, 16'h00FF);
    access(16'hFF7F, 1'b1, 1'b0, 8'h00, 0, lat, nrd, nwr, nen, sa, sd);
    chk("rd FF7F dout", 16'(bus.cpu_data_out), 16'h0025);
    tick();

    // Bus disabled: immediate completion with zero data
    cfg(2'd2, 16'h0000);
    access(16'hFF01, 1'b1, 1'b0, 8'h00, 0, lat, nrd, nwr, nen, sa, sd);
    chk("byp latency", 16'(lat), 16'd1);
    chk("byp dout", 16'(bus.cpu_data_out), 16'h0000);
    chk("byp enable", 16'(nen), 16'd0);
    chk("byp strobes", 16'(nrd + nwr), 16'd0);
    tick();
    cfg(2'd2, 16'h0001);

    // Non-hit access is ignored
    bus.cpu_address = 16'h1234; bus.cpu_write = 1'b1; bus.cpu_data_in = 8'h11;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ready || bus.enable || bus.read_redbus || bus.write_redbus) cnt++;
    end
    chk("nonhit hit", 16'(bus.hit_c), 16'd0);
    chk("nonhit activity", 16'(cnt), 16'd0);
    bus.cpu_write = 1'b0;

    // Select 3 changes nothing
    cfg(2'd3, 16'h1201);
    bus.cpu_address = 16'hFF10;
    #1 chk("sel3 hit", 16'(bus.hit_c), 16'd1);

    // Reset during first STROBE cycle
    bus.cpu_address = 16'hFF00; bus.cpu_read = 1'b1;
    tick(); tick();
    chk("pre-rst strobe", 16'(bus.read_redbus), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst rd", 16'(bus.read_redbus), 16'd0);
    chk("mid-rst enable", 16'(bus.enable), 16'd0);
    chk("mid-rst ready", 16'(bus.ready), 16'd0);
    bus.cpu_read = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("post-rst FF00 hit", 16'(bus.hit_c), 16'd0);
    bus.cpu_address = 16'h0005;
    #1 chk("post-rst 0005 hit", 16'(bus.hit_c), 16'd1);
    repeat (3) tick();

    // Read and write together, config write during STROBE is dropped
    cfg(2'd0, 16'hFF00);
    cfg(2'd2, 16'h0001);
    access(16'hFF03, 1'b1, 1'b1, 8'hEE, 2, lat, nrd, nwr, nen, sa, sd);
    chk("both latency", 16'(lat), 16'd5);
    chk("both rd", 16'(nrd), 16'd2);
    chk("both wr", 16'(nwr), 16'd0);
    chk("both devid", 16'(bus.device_id), 16'h0000);
    tick();
    cfg(2'd1, 16'h0007);
    chk("idle devid", 16'(bus.device_id), 16'h0007);

    // Request held through DONE starts a second access
    bus.cpu_address = 16'hFF04; bus.cpu_read = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.ready) cnt++;
    end
    bus.cpu_read = 1'b0;
    chk("held ready count", 16'(cnt), 16'd2);
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
